// File: rtl/bram_sector_server.sv
// Responder for the 512-byte sector handshake: serves sector reads/writes one word
// at a time from a word-addressed backing store behind a toggle req/ack port.
module bram_sector_server #(
   parameter int          LBA_W   = 7,
   parameter int          SECTORS = 128,
   parameter logic [24:0] BASE    = 25'h1000000
) (
   input  logic        clk_sys,
   input  logic        RESET_N,
   input  logic [31:0] sd_lba,
   input  logic        sd_rd,
   input  logic        sd_wr,
   output logic        sd_ack,
   output logic [7:0]  sd_buff_addr,
   output logic [15:0] sd_buff_dout,
   output logic        sd_buff_wr,
   input  logic [15:0] sd_buff_din,
   output logic [24:0] mem_addr,
   output logic [15:0] mem_din,
   output logic        mem_we,
   output logic        mem_req,
   input  logic        mem_ack,
   input  logic [15:0] mem_dout,
   output logic        busy
);

   typedef enum logic [3:0] {
      IDLE, RD_REQ, RD_WAIT, RD_PUT, WR_ADDR, WR_LAT, WR_REQ, WR_WAIT, DONE
   } state_e;

   state_e           state_q;
   logic [LBA_W-1:0] lba_q;
   logic             oor_q;
   logic [7:0]       word_q;
   logic             lat_q;
   logic             ack_q, buff_wr_q, we_q, req_q;
   logic [7:0]       baddr_q;
   logic [15:0]      dout_q, din_q;
   logic [24:0]      addr_q;
   logic [24:0]      word_addr;

   assign word_addr    = BASE + 25'({lba_q, word_q});
   assign sd_ack       = ack_q;
   assign sd_buff_addr = baddr_q;
   assign sd_buff_dout = dout_q;
   assign sd_buff_wr   = buff_wr_q;
   assign mem_addr     = addr_q;
   assign mem_din      = din_q;
   assign mem_we       = we_q;
   assign mem_req      = req_q;
   assign busy         = (state_q != IDLE);

   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= IDLE;
         lba_q     <= '0;
         oor_q     <= 1'b0;
         word_q    <= 8'd0;
         lat_q     <= 1'b0;
         ack_q     <= 1'b0;
         buff_wr_q <= 1'b0;
         we_q      <= 1'b0;
         req_q     <= 1'b0;
         baddr_q   <= 8'd0;
         dout_q    <= 16'd0;
         din_q     <= 16'd0;
         addr_q    <= 25'd0;
      end else begin
         buff_wr_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // Read has priority when both request levels are up.
               if (sd_rd || sd_wr) begin
                  lba_q   <= sd_lba[LBA_W-1:0];
                  oor_q   <= (sd_lba >= 32'(SECTORS));
                  word_q  <= 8'd0;
                  ack_q   <= 1'b1;
                  state_q <= sd_rd ? RD_REQ : WR_ADDR;
               end
            end
            RD_REQ: begin
               if (oor_q) begin
                  dout_q  <= 16'd0;
                  state_q <= RD_PUT;
               end else begin
                  we_q    <= 1'b0;
                  addr_q  <= word_addr;
                  req_q   <= ~req_q;
                  state_q <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (mem_ack == req_q) begin
                  dout_q  <= mem_dout;
                  state_q <= RD_PUT;
               end
            end
            RD_PUT: begin
               baddr_q   <= word_q;
               buff_wr_q <= 1'b1;
               if (word_q == 8'hFF) begin
                  ack_q   <= 1'b0;
                  state_q <= DONE;
               end else begin
                  word_q  <= word_q + 8'd1;
                  state_q <= RD_REQ;
               end
            end
            WR_ADDR: begin
               baddr_q <= word_q;
               lat_q   <= 1'b0;
               state_q <= WR_LAT;
            end
            // Initiator buffer data lands two cycles after the address moves.
            WR_LAT: begin
               if (lat_q) begin
                  din_q   <= sd_buff_din;
                  state_q <= WR_REQ;
               end else begin
                  lat_q <= 1'b1;
               end
            end
            WR_REQ: begin
               if (!oor_q) begin
                  we_q    <= 1'b1;
                  addr_q  <= word_addr;
                  req_q   <= ~req_q;
                  state_q <= WR_WAIT;
               end else if (word_q == 8'hFF) begin
                  ack_q   <= 1'b0;
                  state_q <= DONE;
               end else begin
                  word_q  <= word_q + 8'd1;
                  state_q <= WR_ADDR;
               end
            end
            WR_WAIT: begin
               if (mem_ack == req_q) begin
                  if (word_q == 8'hFF) begin
                     ack_q   <= 1'b0;
                     state_q <= DONE;
                  end else begin
                     word_q  <= word_q + 8'd1;
                     state_q <= WR_ADDR;
                  end
               end
            end
            DONE: begin
               ack_q   <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bram_sector_server.sv
// Directed bench for bram_sector_server: toggle-port memory model, 1-cycle-latency
// initiator buffer, and a negedge monitor tallying strobes and memory accesses.
module tb_bram_sector_server;
   localparam logic [24:0] BASE = 25'h1000000;

   logic        clk_sys = 1'b0;
   logic        RESET_N;
   logic [31:0] sd_lba = 32'd0;
   logic        sd_rd = 1'b0, sd_wr = 1'b0;
   logic        sd_ack;
   logic [7:0]  sd_buff_addr;
   logic [15:0] sd_buff_dout;
   logic        sd_buff_wr;
   logic [15:0] sd_buff_din = 16'd0;
   logic [24:0] mem_addr;
   logic [15:0] mem_din;
   logic        mem_we, mem_req;
   logic        mem_ack;
   logic [15:0] mem_dout;
   logic        busy;

   bram_sector_server #(.LBA_W(7), .SECTORS(128), .BASE(BASE)) dut (
      .clk_sys(clk_sys), .RESET_N(RESET_N), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
      .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
      .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_we(mem_we), .mem_req(mem_req), .mem_ack(mem_ack),
      .mem_dout(mem_dout), .busy(busy)
   );

   always #5 clk_sys = ~clk_sys;

   int checks = 0, errors = 0;
   int lat = 1;
   int mcnt;

   // Backing store: reads return the low half of the word address.
   always @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         mem_ack <= 1'b0;
         mem_dout <= 16'd0;
         mcnt <= 0;
      end else if (mem_req != mem_ack) begin
         if (mcnt >= lat) begin
            if (!mem_we) mem_dout <= mem_addr[15:0];
            mem_ack <= mem_req;
            mcnt <= 0;
         end else begin
            mcnt <= mcnt + 1;
         end
      end
   end

   always @(posedge clk_sys) sd_buff_din <= 16'hA5A5 ^ {8'h00, sd_buff_addr};

   int strobes, rd_bad, togs, wtogs, wr_cnt, wr_bad, ack_rises, ack_falls;
   logic        prev_req = 1'b0, prev_ack = 1'b0;
   logic [31:0] exp_lba = 32'd0;
   logic        exp_oor = 1'b0;
   logic [24:0] last_addr;
   logic [24:0] ea;
   logic [15:0] ew;

   function automatic logic [24:0] word_addr(input int n);
      logic [31:0] l;
      logic [31:0] nn;
      nn = n;
      l = exp_lba + (nn >> 8);
      return BASE + {10'b0, l[6:0], nn[7:0]};
   endfunction

   always @(negedge clk_sys) begin
      if (!RESET_N) begin
         prev_req = 1'b0;
         prev_ack = 1'b0;
      end else begin
         if (sd_buff_wr) begin
            ea = word_addr(strobes);
            ew = exp_oor ? 16'd0 : ea[15:0];
            if (sd_buff_addr !== strobes[7:0] || sd_buff_dout !== ew) rd_bad++;
            strobes++;
         end
         if (mem_req !== prev_req) begin
            togs++;
            last_addr = mem_addr;
            if (mem_we) begin
               wtogs++;
               if (mem_addr !== word_addr(wr_cnt) || mem_din !== (16'hA5A5 ^ {8'h00, wr_cnt[7:0]}))
                  wr_bad++;
               wr_cnt++;
            end
         end
         if (sd_ack && !prev_ack) ack_rises++;
         if (!sd_ack && prev_ack) ack_falls++;
         prev_req = mem_req;
         prev_ack = sd_ack;
      end
   end

   task automatic clear_counts();
      strobes = 0; rd_bad = 0; togs = 0; wtogs = 0;
      wr_cnt = 0; wr_bad = 0; ack_rises = 0; ack_falls = 0;
   endtask

   task automatic tail();
      @(negedge clk_sys);
      #1;
   endtask

   // Raise the request, drop it on ack, return on the negedge where ack is seen low.
   task automatic run_sector(input logic rd, input logic wr, input logic [31:0] lba, output int rise_n);
      int n;
      sd_lba = lba; sd_rd = rd; sd_wr = wr;
      n = 0;
      while (!sd_ack && n < 50) begin @(negedge clk_sys); n++; end
      rise_n = n;
      if (!sd_ack) begin
         checks++; errors++;
         $display("FAIL ack_rise_timeout lba %0d got no ack within %0d cycles", lba, n);
      end
      sd_rd = 1'b0; sd_wr = 1'b0;
      n = 0;
      while (sd_ack && n < 4000) begin @(negedge clk_sys); n++; end
      if (sd_ack) begin
         checks++; errors++;
         $display("FAIL ack_fall_timeout lba %0d ack still high after %0d cycles", lba, n);
      end
   endtask

   task automatic test_reset();
      RESET_N = 1'b1;
      #2 RESET_N = 1'b0;
      #1;
      checks++;
      if ({sd_ack, sd_buff_wr, busy, mem_req, mem_we} !== 5'b0) begin
         errors++; $display("FAIL reset_ctrl got %b want 00000", {sd_ack, sd_buff_wr, busy, mem_req, mem_we});
      end
      checks++;
      if ({sd_buff_addr, sd_buff_dout, mem_addr, mem_din} !== 65'd0) begin
         errors++; $display("FAIL reset_data got %h want 0", {sd_buff_addr, sd_buff_dout, mem_addr, mem_din});
      end
      repeat (2) @(negedge clk_sys);
      RESET_N = 1'b1;
      repeat (2) @(negedge clk_sys);
      checks++;
      if (busy !== 1'b0 || sd_ack !== 1'b0) begin
         errors++; $display("FAIL reset_idle got busy %b ack %b want 0 0", busy, sd_ack);
      end
   endtask

   task automatic test_read();
      int rn;
      exp_lba = 3; exp_oor = 1'b0; lat = 1; clear_counts();
      run_sector(1'b1, 1'b0, 32'd3, rn);
      checks++;
      if (rn !== 1) begin errors++; $display("FAIL read_ack_latency got %0d want 1", rn); end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL read_busy_done got %b want 1", busy); end
      tail();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_idle got %b want 0", busy); end
      checks++;
      if (strobes !== 256) begin errors++; $display("FAIL read_strobes got %0d want 256", strobes); end
      checks++;
      if (rd_bad !== 0) begin errors++; $display("FAIL read_data got %0d bad want 0", rd_bad); end
      checks++;
      if (last_addr !== 25'h10003FF) begin errors++; $display("FAIL read_last_addr got %h want 10003ff", last_addr); end
      checks++;
      if (wtogs !== 0) begin errors++; $display("FAIL read_no_write got %0d want 0", wtogs); end
   endtask

   task automatic test_write();
      int rn;
      exp_lba = 0; exp_oor = 1'b0; lat = 1; clear_counts();
      run_sector(1'b0, 1'b1, 32'd0, rn);
      tail();
      checks++;
      if (wr_cnt !== 256) begin errors++; $display("FAIL write_count got %0d want 256", wr_cnt); end
      checks++;
      if (wr_bad !== 0) begin errors++; $display("FAIL write_data got %0d bad want 0", wr_bad); end
      checks++;
      if (strobes !== 0) begin errors++; $display("FAIL write_strobes got %0d want 0", strobes); end
      checks++;
      if (ack_rises !== 1 || ack_falls !== 1) begin
         errors++; $display("FAIL write_ack got rises %0d falls %0d want 1 1", ack_rises, ack_falls);
      end
   endtask

   task automatic test_both();
      int rn;
      exp_lba = 5; exp_oor = 1'b0; lat = 1; clear_counts();
      run_sector(1'b1, 1'b1, 32'd5, rn);
      tail();
      checks++;
      if (wtogs !== 0) begin errors++; $display("FAIL both_no_write got %0d want 0", wtogs); end
      checks++;
      if (strobes !== 256 || rd_bad !== 0) begin
         errors++; $display("FAIL both_read got strobes %0d bad %0d want 256 0", strobes, rd_bad);
      end
   endtask

   task automatic test_oor();
      int rn;
      exp_lba = 200; exp_oor = 1'b1; clear_counts();
      run_sector(1'b1, 1'b0, 32'd200, rn);
      tail();
      checks++;
      if (strobes !== 256 || rd_bad !== 0) begin
         errors++; $display("FAIL oor_read got strobes %0d bad %0d want 256 0", strobes, rd_bad);
      end
      checks++;
      if (togs !== 0) begin errors++; $display("FAIL oor_read_req got %0d toggles want 0", togs); end
      clear_counts();
      run_sector(1'b0, 1'b1, 32'd200, rn);
      tail();
      checks++;
      if (togs !== 0) begin errors++; $display("FAIL oor_write_req got %0d toggles want 0", togs); end
      checks++;
      if (ack_rises !== 1 || ack_falls !== 1 || strobes !== 0) begin
         errors++; $display("FAIL oor_write_ack got rises %0d falls %0d strobes %0d want 1 1 0",
                            ack_rises, ack_falls, strobes);
      end
      exp_oor = 1'b0;
   endtask

   task automatic test_back_to_back();
      int rn, lat_bad;
      exp_lba = 112; exp_oor = 1'b0; lat = 0; clear_counts(); lat_bad = 0;
      for (int s = 0; s < 16; s++) begin
         run_sector(1'b1, 1'b0, 32'd112 + 32'(s), rn);
         if (s > 0 && rn != 2) lat_bad++;
      end
      tail();
      checks++;
      if (ack_rises !== 16) begin errors++; $display("FAIL chain_acks got %0d want 16", ack_rises); end
      checks++;
      if (strobes !== 4096 || togs !== 4096) begin
         errors++; $display("FAIL chain_words got strobes %0d toggles %0d want 4096 4096", strobes, togs);
      end
      checks++;
      if (rd_bad !== 0) begin errors++; $display("FAIL chain_data got %0d bad want 0", rd_bad); end
      checks++;
      if (last_addr !== 25'h1007FFF) begin errors++; $display("FAIL chain_last_addr got %h want 1007fff", last_addr); end
      checks++;
      if (lat_bad !== 0) begin errors++; $display("FAIL chain_restart got %0d late sectors want 0", lat_bad); end
   endtask

   task automatic test_reset_mid();
      int n, rn;
      exp_lba = 1; exp_oor = 1'b0; lat = 1; clear_counts();
      sd_lba = 32'd1; sd_rd = 1'b1;
      n = 0;
      while (strobes < 100 && n < 2000) begin @(negedge clk_sys); #1; n++; end
      sd_rd = 1'b0;
      checks++;
      if (strobes < 100) begin errors++; $display("FAIL mid_progress got %0d strobes want 100", strobes); end
      #2 RESET_N = 1'b0;
      #1;
      checks++;
      if ({sd_ack, sd_buff_wr, busy, mem_req, mem_we, sd_buff_addr, sd_buff_dout, mem_addr, mem_din} !== 70'd0) begin
         errors++; $display("FAIL mid_reset_outputs got ack %b busy %b addr %h want all 0", sd_ack, busy, mem_addr);
      end
      @(negedge clk_sys);
      RESET_N = 1'b1;
      @(negedge clk_sys);
      #1;
      clear_counts();
      run_sector(1'b1, 1'b0, 32'd1, rn);
      tail();
      checks++;
      if (strobes !== 256 || rd_bad !== 0 || ack_rises !== 1) begin
         errors++; $display("FAIL mid_fresh_read got strobes %0d bad %0d acks %0d want 256 0 1",
                            strobes, rd_bad, ack_rises);
      end
   endtask

   initial begin
      clear_counts();
      test_reset();
      test_read();
      test_write();
      test_both();
      test_oor();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
